// File: rtl/seg_scan_ctrl.sv
// Multiplexed scan controller for a common-anode seven-segment display with
// tear-free double-buffered frame load. Define SEGSCAN_LZS_EN for leading-zero suppression.
`timescale 1ns/1ps
module seg_scan_ctrl #(
  parameter int DIGITS    = 4,
  parameter int DWELL_CYC = 1000,
  parameter int BLANK_CYC = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [4*DIGITS-1:0]   load_data,
  output logic [7:0]            code,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_done
);

  localparam int MAX_CYC = (DWELL_CYC > BLANK_CYC) ? DWELL_CYC : BLANK_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam int IDX_W   = $clog2(DIGITS);
  localparam int FW      = 4 * DIGITS;
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYC - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYC > 0) ? (BLANK_CYC - 1) : 0);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DIGITS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } state_t;

  state_t             state_r, state_nxt_s;
  logic [IDX_W-1:0]   idx_r, idx_nxt_s;
  logic [CNT_W-1:0]   cnt_r, cnt_nxt_s;
  logic               frame_end_s;
  logic [FW-1:0]      active_r, pending_r, disp_frame_s;
  logic               pending_full_r, load_ready_r;
  logic               accept_s, commit_s;
  logic [3:0]         nib_s;
  logic               lit_s;
  logic [DIGITS-1:0]  an_s, an_r;
  logic [7:0]         code_s, code_r;
  logic               frame_done_r;

  assign accept_s   = load_valid & load_ready_r;
  assign commit_s   = frame_done_r & pending_full_r;
  assign load_ready = load_ready_r;
  assign code       = code_r;
  assign an         = an_r;
  assign frame_done = frame_done_r;

  // Scan state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      idx_r   <= '0;
      cnt_r   <= '0;
    end else begin
      state_r <= state_nxt_s;
      idx_r   <= idx_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Next-state logic: dwell/blank timing and digit advance
  always_comb begin
    state_nxt_s = state_r;
    idx_nxt_s   = idx_r;
    cnt_nxt_s   = cnt_r;
    frame_end_s = 1'b0;
    if (!enable) begin
      state_nxt_s = ST_IDLE;
      idx_nxt_s   = '0;
      cnt_nxt_s   = '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          idx_nxt_s   = '0;
          cnt_nxt_s   = '0;
          state_nxt_s = (BLANK_CYC > 0) ? ST_BLANK : ST_SHOW;
        end
        ST_BLANK: begin
          if (cnt_r == BLANK_LAST) begin
            state_nxt_s = ST_SHOW;
            cnt_nxt_s   = '0;
          end else begin
            cnt_nxt_s = cnt_r + CNT_W'(1);
          end
        end
        ST_SHOW: begin
          if (cnt_r == DWELL_LAST) begin
            cnt_nxt_s   = '0;
            state_nxt_s = (BLANK_CYC > 0) ? ST_BLANK : ST_SHOW;
            if (idx_r == IDX_LAST) begin
              idx_nxt_s   = '0;
              frame_end_s = 1'b1;
            end else begin
              idx_nxt_s = idx_r + IDX_W'(1);
            end
          end else begin
            cnt_nxt_s = cnt_r + CNT_W'(1);
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
          idx_nxt_s   = '0;
          cnt_nxt_s   = '0;
        end
      endcase
    end
  end

  // Frame buffers and handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_r       <= '0;
      pending_r      <= '0;
      pending_full_r <= 1'b0;
      load_ready_r   <= 1'b1;
    end else if (commit_s) begin
      active_r       <= pending_r;
      pending_full_r <= 1'b0;
      load_ready_r   <= 1'b1;
    end else if (accept_s) begin
      pending_r      <= load_data;
      pending_full_r <= 1'b1;
      load_ready_r   <= 1'b0;
    end
  end

  // Frame feeding the next display slot; forwards pending data on the commit
  // boundary so digit 0 of the new frame is right even with little or no blanking
  always_comb begin
    if (commit_s || (frame_end_s && pending_full_r)) begin
      disp_frame_s = pending_r;
    end else begin
      disp_frame_s = active_r;
    end
  end

  // Nibble of the digit being entered
  always_comb begin
    nib_s = 4'h0;
    for (int i = 0; i < DIGITS; i++) begin
      nib_s = nib_s | ((idx_nxt_s == IDX_W'(i)) ? disp_frame_s[4*i +: 4] : 4'h0);
    end
  end

`ifdef SEGSCAN_LZS_EN
  // Leading-zero suppression: a digit is lit once any nibble at or above it is nonzero
  always_comb begin
    logic seen;
    seen  = 1'b0;
    lit_s = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      seen  = seen | (|disp_frame_s[4*i +: 4]);
      lit_s = lit_s | ((idx_nxt_s == IDX_W'(i)) & (seen | (i == 0)));
    end
  end
`else
  assign lit_s = 1'b1;
`endif

  // Output decode from the state being entered
  always_comb begin
    an_s   = '1;
    code_s = code_r;
    case (state_nxt_s)
      ST_IDLE:  code_s = 8'h00;
      ST_BLANK: code_s = code_r;
      ST_SHOW: begin
        code_s = {4'h0, nib_s};
        for (int i = 0; i < DIGITS; i++) begin
          an_s[i] = ~((idx_nxt_s == IDX_W'(i)) & lit_s);
        end
      end
      default:  code_s = 8'h00;
    endcase
  end

  // Output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_r         <= '1;
      code_r       <= 8'h00;
      frame_done_r <= 1'b0;
    end else begin
      an_r         <= an_s;
      code_r       <= code_s;
      frame_done_r <= frame_end_s;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: a timeline model predicts every output cycle.
`timescale 1ns/1ps
module tb_seg_scan_ctrl;
  localparam int DIGITS = 4;
  localparam int DWELL  = 4;
  localparam int BLANK  = 2;
  localparam int SLOT   = DWELL + BLANK;
  localparam int PERIOD = DIGITS * SLOT;

  logic        clk, rst_n, enable, load_valid, load_ready, frame_done;
  logic [15:0] load_data;
  logic [7:0]  code;
  logic [3:0]  an;

  seg_scan_ctrl #(.DIGITS(DIGITS), .DWELL_CYC(DWELL), .BLANK_CYC(BLANK)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .load_valid(load_valid),
    .load_ready(load_ready), .load_data(load_data), .code(code), .an(an),
    .frame_done(frame_done)
  );

  typedef struct packed {
    logic [3:0] an;
    logic [7:0] code;
    logic       fd;
    logic       rdy;
  } exp_t;

  exp_t q[$];
  int n_assert = 0;
  int n_fail   = 0;
  int n_sb     = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] req);
    n_assert++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h at %0t", nm, got, req, $time);
    end
  endtask

  // Reference model: position on the scan timeline, in whole cycles since enable
  bit          m_run, m_full, m_fd;
  int          m_t;
  logic [15:0] m_active, m_pending;
  logic [7:0]  m_code;

  always @(posedge clk or negedge rst_n) begin
    exp_t e;
    int ph, slot, off;
    bit commit, accept, lit;
    if (!rst_n) begin
      m_run = 0; m_full = 0; m_fd = 0; m_t = 0;
      m_active = 16'h0; m_pending = 16'h0; m_code = 8'h00;
      q.delete();
      e.an = 4'hF; e.code = 8'h00; e.fd = 1'b0; e.rdy = 1'b1;
      q.push_back(e);
    end else begin
      commit = m_fd && m_full;
      accept = load_valid && !m_full;
      if (commit) begin
        m_active = m_pending;
        m_full   = 0;
      end else if (accept) begin
        m_pending = load_data;
        m_full    = 1;
      end
      e.an = 4'hF;
      if (!enable) begin
        m_run = 0; m_t = 0; m_fd = 0; m_code = 8'h00;
      end else begin
        if (!m_run) begin
          m_run = 1;
          m_t   = 0;
        end else begin
          m_t++;
        end
        m_fd = (m_t > 0) && (m_t % PERIOD == 0);
        ph   = m_t % PERIOD;
        slot = ph / SLOT;
        off  = ph % SLOT;
        if (off >= BLANK) begin
          m_code = {4'h0, m_active[4*slot +: 4]};
`ifdef SEGSCAN_LZS_EN
          lit = (slot == 0) || ((m_active >> (4 * slot)) != 16'h0);
`else
          lit = 1;
`endif
          if (lit) e.an = ~(4'b0001 << slot);
        end
      end
      e.code = m_code;
      e.fd   = m_fd;
      e.rdy  = !m_full;
      q.push_back(e);
    end
  end

  // Monitor: one expected entry per cycle, compared away from the clock edge
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      n_sb++;
      chk("an", {28'h0, an}, {28'h0, e.an});
      chk("code", {24'h0, code}, {24'h0, e.code});
      chk("frame_done", {31'h0, frame_done}, {31'h0, e.fd});
      chk("load_ready", {31'h0, load_ready}, {31'h0, e.rdy});
    end
  end

  task automatic send(input logic [15:0] d);
    int k;
    load_valid = 1'b1;
    load_data  = d;
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      if (load_ready === 1'b1) break;
    end
    chk("accept_timeout", k, (k < 200) ? k : 0);
    @(posedge clk);
    #1 load_valid = 1'b0;
  endtask

  task automatic wait_an(input logic [3:0] pat);
    int k;
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      if (an === pat) break;
    end
    chk("an_wait_timeout", k, (k < 200) ? k : 0);
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; load_valid = 1'b0; load_data = 16'h0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1; enable = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    send(16'h1A3F);
    send(16'h5B2C);
    repeat (2 * PERIOD) @(posedge clk);
    // drop enable while digit 2 is lit
    wait_an(4'b1011);
    @(posedge clk);
    #1 enable = 1'b0;
    repeat (10) @(posedge clk);
    #1 enable = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    send(16'h7777);
    send(16'h8888);
    wait_an(4'b1101);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_an", {28'h0, an}, 32'hF);
    chk("async_rst_code", {24'h0, code}, 32'h0);
    chk("async_rst_ready", {31'h0, load_ready}, 32'h1);
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (PERIOD + 4) @(posedge clk);
    #1;
    send(16'h0050);
    repeat (3 * PERIOD) @(posedge clk);
    #1;
    send(16'h0000);
    repeat (3 * PERIOD) @(posedge clk);
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      enable     = ($urandom_range(0, 63) != 0);
      load_valid = ($urandom_range(0, 3) == 0);
      load_data  = 16'($urandom);
    end
    @(posedge clk);
    #1 enable = 1'b0; load_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("scoreboard_activity", (n_sb > 3000) ? 32'h1 : 32'h0, 32'h1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Time-multiplexed scan controller for a DIGITS-wide common-anode seven-segment display. It holds a frame of hex nibbles and cycles through the digits one at a time. For each digit it drives the nibble code to the existing hex-to-segment decoder (8-bit code input, 7-bit active-high segment output) and enables the matching anode. New frame data arrives over a valid/ready handshake and is committed only at frame boundaries, so the display never tears.

Parameters:
DIGITS, 4, number of digits scanned (2..8)
DWELL_CYC, 1000, clock cycles each digit is lit (>=1)
BLANK_CYC, 16, all-anodes-off cycles before each digit (0 = no blanking)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
enable  in  1  scan enable; low forces IDLE
load_valid  in  1  frame data offered
load_ready  out  1  controller can accept a frame
load_data  in  4*DIGITS  nibble i = load_data[4i+3:4i]; digit 0 is least significant
code  out  8  {4'b0, nibble} to decoder input
an  out  DIGITS  anode enables, active-low, at most one bit low
frame_done  out  1  one-cycle pulse at end of each full scan

Behaviour:
- All outputs are registered.
- Reset values: state=IDLE, idx=0, cnt=0, active frame=0, pending empty, load_ready=1, an=all 1s, code=0, frame_done=0.
- Storage: active register (currently displayed) and pending register with full flag.
- load_ready = !pending_full.
- Accept occurs when load_valid && load_ready: the pending register captures load_data and pending_full is set on the next edge.
- Commit: when frame_done fires and pending_full=1, copy pending into active and clear pending_full on the same edge. load_ready goes high the following cycle.
- An accept and a commit never coincide, because load_ready=0 whenever pending_full=1.
- IDLE:
  - an=all 1s, code=0, idx=0, cnt=0.
  - enable=1 moves to BLANK, or to SHOW directly when BLANK_CYC=0.
- BLANK:
  - an=all 1s; code holds its previous value.
  - Lasts exactly BLANK_CYC cycles, then goes to SHOW.
- SHOW:
  - an[idx]=0, all other anode bits 1; code={4'b0, active[idx]}.
  - Lasts exactly DWELL_CYC cycles.
  - On exit, idx increments, wrapping DIGITS-1 -> 0, and the state returns to BLANK (or to SHOW with the next idx when BLANK_CYC=0).
- frame_done is high for exactly the one cycle following the last SHOW cycle of idx=DIGITS-1.
- The commit takes effect from the next SHOW of idx 0.
- Frame period = DIGITS*(DWELL_CYC+BLANK_CYC) cycles.
- enable falling in any state: the next edge returns to IDLE, idx=0, cnt=0, an=all 1s, and no frame_done is generated.
  - Pending contents and the handshake are unaffected, so loads are still accepted while in IDLE.
- Commit happens only on frame_done. While disabled, a pending frame stays pending.
- Re-enable always restarts the scan at idx 0.
- Asynchronous reset mid-scan: all state returns to reset values immediately. Pending data is lost.
- cnt is sized ceil(log2(max(DWELL_CYC, BLANK_CYC)+1)) bits; idx is ceil(log2(DIGITS)) bits.

Optional Feature:
SEGSCAN_LZS_EN:
- When defined: leading-zero suppression. Working down from digit DIGITS-1, every zero nibble that precedes the first nonzero nibble is blanked: its SHOW slot keeps an=all 1s while retaining full slot timing. Digit 0 is always shown. Suppression is evaluated on the active register.
- When undefined: all digits are always lit; there is no suppression logic.

Test Plan:
- Reset, DIGITS=4, DWELL_CYC=4, BLANK_CYC=2, enable=1, no load -> an sequence 1111 x2, 1110 x4, 1111 x2, 1101 x4, ...; code=0; frame_done pulses every 24 cycles.
- Load 16'h1A3F while the scan runs -> load_ready drops 1 cycle after accept. At the next frame_done, load_ready rises the cycle after. The next frame shows code 0x0F, 0x03, 0x0A, 0x01 on an 1110, 1101, 1011, 0111.
- Second load_valid held while pending is full -> not accepted until commit. Exactly one accept occurs the cycle after load_ready rises.
- enable dropped during SHOW idx=2 -> an=1111 next cycle, no frame_done. Re-enable restarts at idx 0 after the BLANK interval.
- rst_n pulsed low mid-SHOW -> an=1111, code=0, load_ready=1 asynchronously. The pending frame is discarded.
- SEGSCAN_LZS_EN, active=16'h0050 -> digits 3 and 2 keep an=1111 during their slots; digits 1 (code 0x05) and 0 (code 0x00) are lit. With active=16'h0000, only digit 0 is lit.
